// File: rtl/fifo_read_ctrl_pkg.sv
// fifo_read_ctrl_pkg: FSM state encoding and default widths shared by the read-side controller.
package fifo_read_ctrl_pkg;
    localparam int TAMANO_DATOS_DEF = 12;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;
endpackage

// File: rtl/fifo_read_ctrl_if.sv
// fifo_read_ctrl_if: source-FIFO pins plus downstream valid/ready port of the read controller.
interface fifo_read_ctrl_if import fifo_read_ctrl_pkg::*; #(
    parameter int W = TAMANO_DATOS_DEF
) ();
    logic         fifo_empty;
    logic [W-1:0] fifo_data;
    logic         fifo_rd_en;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         ready_in;
    modport master (input fifo_empty, fifo_data, ready_in, output fifo_rd_en, data_out, valid_out);
    modport slave  (output fifo_empty, fifo_data, ready_in, input fifo_rd_en, data_out, valid_out);
endinterface

// File: rtl/fifo_read_ctrl_skid_buffer2.sv
// skid_buffer2: 2-entry FIFO-ordered holding buffer; dout is the head entry.
module skid_buffer2 #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);
    logic [W-1:0] tail;
    logic [1:0]   base;
    // occupancy after this cycle's pop decides which slot a returning word lands in
    assign base = occ - 2'(pop);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (pop) dout <= tail;
            if (push && base == 2'd0) dout <= din;
            if (push && base != 2'd0) tail <= din;
            occ <= base + 2'(push);
        end
    end
endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: pops a registered-read FIFO and presents words downstream on valid/ready,
// hiding the one-cycle read latency behind a 2-entry skid buffer.
module fifo_read_ctrl import fifo_read_ctrl_pkg::*; #(
    parameter int TAMANO_DATOS = TAMANO_DATOS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pause,
    fifo_read_ctrl_if.master     bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     words_sent
);
    state_t                  state;
    logic                    inflight;
    logic                    pop;
    logic [1:0]              occ;
    logic [TAMANO_DATOS-1:0] head;
    assign pop           = bus.valid_out & bus.ready_in;
    assign bus.valid_out = occ != 2'd0;
    assign bus.data_out  = head;
    // a head popped this cycle frees its slot for the word returning next cycle
    assign bus.fifo_rd_en = state == ST_STREAM && !bus.fifo_empty && !pause
                            && (occ + 2'(inflight) - 2'(pop)) < 2'd2;
    assign busy = state != ST_IDLE || occ != 2'd0 || inflight;
    skid_buffer2 #(.W(TAMANO_DATOS)) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .din   (bus.fifo_data),
        .dout  (head),
        .occ   (occ)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            inflight   <= 1'b0;
            words_sent <= '0;
        end else begin
            inflight   <= bus.fifo_rd_en;
            words_sent <= words_sent + CNT_W'(pop);
            case (state)
                ST_IDLE:   state <= enable ? ST_STREAM : ST_IDLE;
                ST_STREAM: state <= enable ? ST_STREAM : ST_FLUSH;
                ST_FLUSH:  state <= enable ? ST_STREAM : (occ == 2'd0 && !inflight) ? ST_IDLE : ST_FLUSH;
                default:   state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: directed bench with a registered-read FIFO model feeding the controller.
module tb_fifo_read_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pause;
    logic       busy;
    logic [3:0] words_sent;
    logic [11:0] mem [0:63];
    int wp = 0;
    int rp = 0;
    int rd_count = 0;
    int checks = 0;
    int fails = 0;
    int n;

    fifo_read_ctrl_if #(.W(12)) bus ();

    fifo_read_ctrl #(.TAMANO_DATOS(12), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pause      (pause),
        .bus        (bus),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    assign bus.fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_data <= mem[rp];
            rp <= rp + 1;
            rd_count <= rd_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            mem[wp] = base + 12'(i);
            wp = wp + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [11:0] exp);
        chk({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
        chk({tag, "_data"}, 32'(bus.data_out), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        pause = 1'b0;
        bus.ready_in = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(bus.valid_out), 0);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_words", 32'(words_sent), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rden", 32'(bus.fifo_rd_en), 0);

        // streaming 0x001..0x008
        reset = 1'b0;
        enable = 1'b1;
        load(12'h001, 8);
        #1;
        chk("st_idle_rden", 32'(bus.fifo_rd_en), 0);
        tick();
        chk("st_first_rden", 32'(bus.fifo_rd_en), 1);
        chk("st_first_valid", 32'(bus.valid_out), 0);
        tick();
        chk("st_lat_valid", 32'(bus.valid_out), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_word("st_word", 12'h001 + 12'(i));
        end
        chk("st_no_extra_rden", 32'(bus.fifo_rd_en), 0);
        tick();
        chk("st_drained", 32'(bus.valid_out), 0);
        chk("st_words", 32'(words_sent), 8);
        chk("st_rdcount", 32'(rd_count), 8);

        // backpressure
        bus.ready_in = 1'b0;
        load(12'h101, 4);
        #1;
        chk("bp_rden0", 32'(bus.fifo_rd_en), 1);
        tick();
        chk("bp_rden1", 32'(bus.fifo_rd_en), 1);
        tick();
        chk("bp_rden_drop", 32'(bus.fifo_rd_en), 0);
        tick();
        chk("bp_rden_held", 32'(bus.fifo_rd_en), 0);
        chk_word("bp_hold", 12'h101);
        tick();
        chk("bp_rden_held2", 32'(bus.fifo_rd_en), 0);
        chk_word("bp_stable", 12'h101);
        bus.ready_in = 1'b1;
        #1;
        chk("bp_resume_rden", 32'(bus.fifo_rd_en), 1);
        for (int i = 0; i < 4; i++) begin
            chk_word("bp_word", 12'h101 + 12'(i));
            tick();
        end
        chk("bp_drained", 32'(bus.valid_out), 0);
        chk("bp_words", 32'(words_sent), 12);

        // pause for 5 cycles
        load(12'h201, 6);
        #1;
        chk("pa_rden0", 32'(bus.fifo_rd_en), 1);
        tick();
        pause = 1'b1;
        #1;
        chk("pa_rden_off", 32'(bus.fifo_rd_en), 0);
        tick();
        chk("pa_rden_off", 32'(bus.fifo_rd_en), 0);
        chk_word("pa_buffered", 12'h201);
        repeat (3) begin
            tick();
            chk("pa_rden_off", 32'(bus.fifo_rd_en), 0);
            chk("pa_valid_off", 32'(bus.valid_out), 0);
        end
        tick();
        pause = 1'b0;
        #1;
        chk("pa_resume_rden", 32'(bus.fifo_rd_en), 1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_word("pa_word", 12'h202 + 12'(i));
            tick();
        end
        chk("pa_drained", 32'(bus.valid_out), 0);
        chk("pa_words_wrap", 32'(words_sent), 2);

        // flush with one held and one in flight
        load(12'h301, 5);
        #1;
        chk("fl_rden0", 32'(bus.fifo_rd_en), 1);
        tick();
        chk("fl_rden1", 32'(bus.fifo_rd_en), 1);
        enable = 1'b0;
        tick();
        chk("fl_no_rden", 32'(bus.fifo_rd_en), 0);
        chk("fl_busy", 32'(busy), 1);
        chk_word("fl_word0", 12'h301);
        tick();
        chk("fl_no_rden", 32'(bus.fifo_rd_en), 0);
        chk_word("fl_word1", 12'h302);
        tick();
        chk("fl_empty_valid", 32'(bus.valid_out), 0);
        chk("fl_empty_busy", 32'(busy), 1);
        tick();
        chk("fl_idle_busy", 32'(busy), 0);
        chk("fl_words", 32'(words_sent), 4);
        chk("fl_rdcount", 32'(rd_count), 20);
        enable = 1'b1;
        tick();
        chk("re_rden0", 32'(bus.fifo_rd_en), 1);
        tick();
        chk("re_rden1", 32'(bus.fifo_rd_en), 1);
        enable = 1'b0;
        tick();
        chk("re_flush_rden", 32'(bus.fifo_rd_en), 0);
        chk_word("re_word0", 12'h303);
        enable = 1'b1;
        tick();
        chk("re_stream_rden", 32'(bus.fifo_rd_en), 1);
        chk_word("re_word1", 12'h304);
        tick();
        chk("re_gap", 32'(bus.valid_out), 0);
        tick();
        chk_word("re_word2", 12'h305);
        tick();
        chk("re_drained", 32'(bus.valid_out), 0);
        chk("re_words", 32'(words_sent), 7);

        // reset mid-stream with a word held and one in flight
        bus.ready_in = 1'b0;
        load(12'h401, 4);
        #1;
        chk("mr_rden0", 32'(bus.fifo_rd_en), 1);
        tick();
        tick();
        chk("mr_held", 32'(bus.valid_out), 1);
        reset = 1'b1;
        #1;
        chk("mr_valid", 32'(bus.valid_out), 0);
        chk("mr_words", 32'(words_sent), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_data", 32'(bus.data_out), 0);
        tick();
        reset = 1'b0;
        bus.ready_in = 1'b1;
        #1;
        chk("mr_idle_rden", 32'(bus.fifo_rd_en), 0);
        tick();
        chk("mr_first_rden", 32'(bus.fifo_rd_en), 1);
        tick();
        tick();
        chk_word("mr_word0", 12'h403);
        tick();
        chk_word("mr_word1", 12'h404);
        tick();
        chk("mr_drained", 32'(bus.valid_out), 0);
        chk("mr_words2", 32'(words_sent), 2);

        // counter wrap: 2 + 15 = 17 handshakes on a 4-bit counter
        load(12'h501, 15);
        n = 0;
        for (int k = 0; k < 60 && n < 15; k++) begin
            tick();
            if (bus.valid_out) begin
                chk("wr_data", 32'(bus.data_out), 32'(12'h501 + 12'(n)));
                n++;
            end
        end
        chk("wr_count", 32'(n), 15);
        tick();
        chk("wr_words", 32'(words_sent), 1);
        chk("wr_rdcount", 32'(rd_count), 42);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
